// File: rtl/fsm_pkg.sv
// Shared encodings and reset constants for the serializer and the sequence detectors.
package fsm_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_PAR   = 2'd2
  } ser_state_e;

  // Every block in this family uses a synchronous, active-high reset on clk.
  localparam logic RESET_ACTIVE = 1'b1;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with zero flag; saturates at zero instead of wrapping.
module bit_down_counter
  import fsm_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial streamer with valid/ready load and gapless back-to-back frames.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             accept, head_bit;
  logic [WIDTH-1:0] shifted;

  assign accept   = load_valid && load_ready;
  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE)
      par_q <= 1'b0;
    else
      par_q <= par_d;
  end
`endif

  bit_down_counter #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LAST),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      SER_IDLE: begin
        if (accept) begin
          state_d  = SER_SHIFT;
          shreg_d  = load_data;
          cnt_load = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
          par_d    = ^load_data;
`endif
        end
      end
      SER_SHIFT: begin
        if (!cnt_zero) begin
          shreg_d = shifted;
          cnt_dec = 1'b1;
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = SER_PAR;
`else
          // Reload on the last bit so the next word follows with no idle cycle.
          if (accept) begin
            shreg_d  = load_data;
            cnt_load = 1'b1;
          end else begin
            state_d = SER_IDLE;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      SER_PAR: begin
        if (accept) begin
          state_d  = SER_SHIFT;
          shreg_d  = load_data;
          cnt_load = 1'b1;
          par_d    = ^load_data;
        end else begin
          state_d = SER_IDLE;
        end
      end
`endif
      default: state_d = SER_IDLE;
    endcase
  end

  always_comb begin
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    frame_last = 1'b0;
    case (state_q)
      SER_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = head_bit;
`ifndef BIT_SERIALIZER_PARITY_EN
        frame_last = cnt_zero;
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      SER_PAR: begin
        ser_valid  = 1'b1;
        ser_out    = par_q;
        frame_last = 1'b1;
      end
`endif
      default: ;
    endcase
    load_ready = (reset != RESET_ACTIVE) && ((state_q == SER_IDLE) || frame_last);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_LEN = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic m_load_ready, m_ser_out, m_ser_valid, m_frame_last;
  logic l_load_ready, l_ser_out, l_ser_valid, l_frame_last;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_last(m_frame_last)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_load_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_last(l_frame_last)
  );

  typedef struct {logic b; logic last;} bit_t;
  typedef struct {
    logic r; logic v; logic [W-1:0] d;
    logic so; logic sv; logic fl; logic lr;
  } vec_t;

  bit_t qm[$];
  bit_t ql[$];
  vec_t vecs[12];
  vec_t nov;
  int   n_vec = 0;
  int   checks = 0;
  int   errors = 0;
  logic acc = 1'b0;
  logic [2:0] hist = '0;
  int   cnt101 = 0;
  int   nvalid = 0;
  int   nready = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: each accepted word becomes a list of (bit, last) entries, one per output cycle.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back('{b: d[W-1-i], last: (i == W-1) && !PAR});
      ql.push_back('{b: d[i],     last: (i == W-1) && !PAR});
    end
    if (PAR) begin
      qm.push_back('{b: ^d, last: 1'b1});
      ql.push_back('{b: ^d, last: 1'b1});
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input bit use_tab, input vec_t tv);
    logic e_sv, e_mo, e_lo, e_fl, e_lr;
    @(negedge clk);
    reset = r; load_valid = v; load_data = d;
    #1;
    e_sv = (qm.size() > 0);
    e_mo = e_sv ? qm[0].b : 1'b0;
    e_lo = e_sv ? ql[0].b : 1'b0;
    e_fl = e_sv ? qm[0].last : 1'b0;
    e_lr = !r && (!e_sv || e_fl);
    chk("msb ser_valid", m_ser_valid, e_sv);
    chk("msb ser_out", m_ser_out, e_mo);
    chk("msb frame_last", m_frame_last, e_fl);
    chk("msb load_ready", m_load_ready, e_lr);
    chk("lsb ser_valid", l_ser_valid, e_sv);
    chk("lsb ser_out", l_ser_out, e_lo);
    chk("lsb frame_last", l_frame_last, e_fl);
    chk("lsb load_ready", l_load_ready, e_lr);
    if (use_tab) begin
      chk("tab ser_out", m_ser_out, tv.so);
      chk("tab ser_valid", m_ser_valid, tv.sv);
      chk("tab frame_last", m_frame_last, tv.fl);
      chk("tab load_ready", m_load_ready, tv.lr);
    end
    if (m_ser_valid === 1'b1) begin
      hist = {hist[1:0], m_ser_out};
      if (hist == 3'b101) cnt101++;
      nvalid++;
      if (m_load_ready === 1'b1) nready++;
    end
    acc = v && e_lr;
    @(posedge clk);
    if (r) begin
      qm.delete();
      ql.delete();
    end else begin
      if (e_sv) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_word(d);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
    step(r, v, d, 1'b0, nov);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  // Holds load_valid/load_data until the handshake completes (bounded).
  task automatic send(input logic [W-1:0] d, output int waited);
    waited = 0;
    do begin
      drive(1'b0, 1'b1, d);
      waited++;
    end while (!acc && waited < 40);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send timeout: word %h not accepted after %0d cycles", d, waited);
    end
  endtask

  task automatic addv(input logic r, input logic v, input logic [W-1:0] d,
                      input logic so, input logic sv, input logic fl, input logic lr);
    vecs[n_vec] = '{r: r, v: v, d: d, so: so, sv: sv, fl: fl, lr: lr};
    n_vec++;
  endtask

  initial begin
    int   w;
    logic pend;
    logic [W-1:0] pd;
    logic np;
    nov = '{r: 1'b0, v: 1'b0, d: '0, so: 1'b0, sv: 1'b0, fl: 1'b0, lr: 1'b0};
    np  = !PAR;

    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 8'hA0 MSB first: 1,0,1,0,0,0,0,0 (+ parity 0 when enabled)
    addv(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, np,   np);
    if (PAR) addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    addv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    hist = '0; cnt101 = 0;
    for (int i = 0; i < n_vec; i++)
      step(vecs[i].r, vecs[i].v, vecs[i].d, 1'b1, vecs[i]);
    chk_int("detector 101 hits", cnt101, 1);

    // Back-to-back FF then 00 with load_valid held high
    nvalid = 0; nready = 0;
    send(8'hFF, w);
    chk_int("first accept wait", w, 1);
    send(8'h00, w);
    chk_int("b2b accept wait", w, FRAME_LEN);
    idle(FRAME_LEN + 2);
    chk_int("b2b valid cycles", nvalid, 2 * FRAME_LEN);
    chk_int("b2b ready in frame", nready, 2);

    send(8'h01, w);
    idle(FRAME_LEN + 1);

    // Reset on the 4th bit of FF, then a clean 80
    send(8'hFF, w);
    idle(3);
    drive(1'b1, 1'b0, 8'h00);
    idle(1);
    send(8'h80, w);
    chk_int("post-reset accept wait", w, 1);
    idle(FRAME_LEN + 1);

    // Word offered mid-frame is held until the frame-last cycle
    send(8'hC3, w);
    idle(2);
    send(8'h55, w);
    chk_int("hold accept wait", w, FRAME_LEN - 2);
    idle(FRAME_LEN + 1);

    send(8'h07, w);
    send(8'h03, w);
    idle(FRAME_LEN + 1);

    pend = 1'b0; pd = '0;
    for (int c = 0; c < 500; c++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pd   = W'($urandom);
      end
      drive(r, pend, pd);
      if (acc) pend = 1'b0;
    end
    idle(FRAME_LEN + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
